// File: rtl/demux4_stream_pkg.sv
// demux4_pkg: shared channel count, channel index type and round-robin wrap helper
package demux4_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  typedef logic [CH_W-1:0] ch_idx_t;
  function automatic ch_idx_t next_rr(ch_idx_t idx);
    return ch_idx_t'(idx + 1'b1);
  endfunction
endpackage

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: stream bus (in_data/in_valid/in_ready/sel/auto in, out_data/out_valid/out_ready per channel); slave=demux, master=producer+consumers
interface demux4_stream_if import demux4_pkg::*; #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  ch_idx_t sel;
  logic auto;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  modport slave (input in_data, in_valid, sel, auto, out_ready, output in_ready, out_data, out_valid);
  modport master (output in_data, in_valid, sel, auto, out_ready, input in_ready, out_data, out_valid);
endinterface

// File: rtl/demux4_stream_out_reg.sv
// demux_out_reg: one-entry channel register (clk, rst, load/d in, q/valid out, ready in); load wins over a same-cycle drain
module demux_out_reg #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic valid,
  input  logic ready
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q <= d;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: 1:4 stream demux (clk, rst, bus slave, rr_ptr/beat_cnt out) routing by sel or round-robin into per-channel registers
module demux4_stream import demux4_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  demux4_stream_if.slave bus,
  output ch_idx_t rr_ptr,
  output logic [CNT_W-1:0] beat_cnt
);
  ch_idx_t t;
  logic acc;
  always_comb begin
    t = bus.auto ? rr_ptr : bus.sel;
    bus.in_ready = ~rst & (~bus.out_valid[t] | bus.out_ready[t]);
    acc = bus.in_valid & bus.in_ready;
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_out_reg #(.WIDTH(WIDTH)) u_reg (
      .clk(clk),
      .rst(rst),
      .load(acc && t == ch_idx_t'(k)),
      .d(bus.in_data),
      .q(bus.out_data[k*WIDTH +: WIDTH]),
      .valid(bus.out_valid[k]),
      .ready(bus.out_ready[k])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else if (acc) begin
      rr_ptr <= bus.auto ? next_rr(rr_ptr) : rr_ptr;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed self-checking bench for demux4_stream
module tb_demux4_stream;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] rr_ptr;
  logic [3:0] beat_cnt;
  int checks = 0;
  int errors = 0;
  demux4_stream_if #(.WIDTH(8)) bus ();
  demux4_stream #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .rr_ptr(rr_ptr),
    .beat_cnt(beat_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ch(int k);
    return bus.out_data[k*8 +: 8];
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hFF;
    bus.sel = 2'd0;
    bus.auto = 1'b0;
    bus.out_ready = 4'h0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset in_ready", 32'(bus.in_ready), 0);
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset out_data", bus.out_data, 0);
      chk("reset rr_ptr", 32'(rr_ptr), 0);
      chk("reset beat_cnt", 32'(beat_cnt), 0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_sel();
    do_reset();
    bus.auto = 1'b0;
    bus.out_ready = 4'hF;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA0;
    bus.sel = 2'd2;
    #1 chk("sel in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    chk("sel first valid", 32'(bus.out_valid), 32'b0100);
    chk("sel first data", 32'(ch(2)), 32'hA0);
    bus.in_data = 8'hB1;
    bus.sel = 2'd0;
    @(negedge clk);
    chk("sel second valid", 32'(bus.out_valid), 32'b0001);
    chk("sel second data", 32'(ch(0)), 32'hB1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sel drained", 32'(bus.out_valid), 0);
    chk("sel data held", 32'(ch(2)), 32'hA0);
    chk("sel beat_cnt", 32'(beat_cnt), 2);
  endtask
  task automatic test_round_robin();
    do_reset();
    bus.auto = 1'b1;
    bus.sel = 2'd3;
    bus.out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h10 + i);
      #1 chk("rr in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);
      chk("rr valid", 32'(bus.out_valid), 32'(1 << (i % 4)));
      chk("rr data", 32'(ch(i % 4)), 32'(8'h10 + i));
    end
    bus.in_valid = 1'b0;
    chk("rr ptr", 32'(rr_ptr), 2);
    chk("rr beat_cnt", 32'(beat_cnt), 6);
  endtask
  task automatic test_backpressure();
    do_reset();
    bus.auto = 1'b0;
    bus.out_ready = 4'b1101;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h22;
    bus.sel = 2'd1;
    #1 chk("bp first ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    chk("bp ch1 valid", 32'(bus.out_valid), 32'b0010);
    bus.in_data = 8'h33;
    #1 chk("bp stall ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("bp stall valid", 32'(bus.out_valid), 32'b0010);
    chk("bp stall data", 32'(ch(1)), 32'h22);
    chk("bp stall cnt", 32'(beat_cnt), 1);
    bus.sel = 2'd3;
    bus.in_data = 8'h44;
    #1 chk("bp resel ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    chk("bp ch3 valid", 32'(bus.out_valid), 32'b1010);
    chk("bp ch3 data", 32'(ch(3)), 32'h44);
    chk("bp ch1 kept", 32'(ch(1)), 32'h22);
    bus.in_valid = 1'b0;
    bus.out_ready = 4'hF;
    @(negedge clk);
    chk("bp drained", 32'(bus.out_valid), 0);
    chk("bp beat_cnt", 32'(beat_cnt), 2);
  endtask
  task automatic test_drain_load();
    do_reset();
    bus.auto = 1'b0;
    bus.out_ready = 4'h0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    bus.sel = 2'd0;
    @(negedge clk);
    chk("dl hold valid", 32'(bus.out_valid), 32'b0001);
    chk("dl hold data", 32'(ch(0)), 32'h55);
    bus.out_ready = 4'b0001;
    bus.in_data = 8'h66;
    #1 chk("dl in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    chk("dl no bubble", 32'(bus.out_valid), 32'b0001);
    chk("dl new data", 32'(ch(0)), 32'h66);
    chk("dl beat_cnt", 32'(beat_cnt), 2);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("dl drained", 32'(bus.out_valid), 0);
  endtask
  task automatic test_wrap_reset();
    do_reset();
    bus.auto = 1'b0;
    bus.sel = 2'd1;
    bus.out_ready = 4'hF;
    bus.in_data = 8'h77;
    bus.in_valid = 1'b1;
    repeat (17) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("wrap beat_cnt", 32'(beat_cnt), 1);
    @(negedge clk);
    bus.out_ready = 4'h0;
    bus.auto = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("wrap rr valid", 32'(bus.out_valid), 32'b0111);
    chk("wrap rr ptr", 32'(rr_ptr), 3);
    chk("wrap cnt", 32'(beat_cnt), 4);
    rst = 1'b1;
    #1 chk("mid rst in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("mid rst valid", 32'(bus.out_valid), 0);
    chk("mid rst data", bus.out_data, 0);
    chk("mid rst ptr", 32'(rr_ptr), 0);
    chk("mid rst cnt", 32'(beat_cnt), 0);
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_sel();
    test_round_robin();
    test_backpressure();
    test_drain_load();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
